// File: rtl/fpga_bridge_pkg.sv
// Shared types for the AXI-Lite to APB bridge:
// FSM states, response codes and the captured transfer.
package fpga_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

endpackage

// File: rtl/fpga_axil_apb_bridge.sv
// AXI-Lite slave to APB master bridge, one transfer
// in flight, alternating write/read priority on contention.
module fpga_axil_apb_bridge
  import fpga_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        core_clk,
  input  logic        rst_b,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic [31:0] m_apb_paddr,
  output logic        m_apb_psel,
  output logic        m_apb_penable,
  output logic        m_apb_pwrite,
  output logic [31:0] m_apb_pwdata,
  input  logic [31:0] m_apb_prdata,
  input  logic        m_apb_pready,
  input  logic        m_apb_pslverr
);

  localparam int unsigned CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e        state_q, state_d;
  txn_t          txn_q;
  logic          wr_first_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    resp_q;
  logic [31:0]   rdata_q;

  logic wr_ok, rd_ok, contest;
  logic grant_wr, grant_rd;
  logic timeout, finish, resp_ack;

  always_comb begin
    wr_ok    = s_axil_awvalid & s_axil_wvalid;
    rd_ok    = s_axil_arvalid;
    contest  = wr_ok & rd_ok;
    grant_wr = (state_q == ST_IDLE) & wr_ok
             & (~rd_ok | wr_first_q);
    grant_rd = (state_q == ST_IDLE) & rd_ok
             & (~wr_ok | ~wr_first_q);
    timeout  = (TIMEOUT_CYC != 0) & (cnt_q == TO_VAL)
             & ~m_apb_pready;
    finish   = (state_q == ST_ACCESS)
             & (m_apb_pready | timeout);
    resp_ack = txn_q.write ? s_axil_bready
                           : s_axil_rready;
    state_d  = state_q;
    unique case (state_q)
      ST_IDLE:
        if (grant_wr | grant_rd) state_d = ST_SETUP;
      ST_SETUP:
        state_d = ST_ACCESS;
      ST_ACCESS:
        if (finish) state_d = ST_RESP;
      ST_RESP:
        if (resp_ack) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge core_clk or negedge rst_b) begin
    if (!rst_b) begin
      txn_q      <= '0;
      wr_first_q <= 1'b1;
      cnt_q      <= '0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      if (grant_wr) begin
        txn_q.write <= 1'b1;
        txn_q.addr  <= s_axil_awaddr & WORD_MASK;
        txn_q.data  <= s_axil_wdata;
      end else if (grant_rd) begin
        txn_q.write <= 1'b0;
        txn_q.addr  <= s_axil_araddr & WORD_MASK;
        txn_q.data  <= '0;
      end
      if ((grant_wr | grant_rd) & contest) begin
        wr_first_q <= ~wr_first_q;
      end
      if (state_q == ST_SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ST_ACCESS && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // pready beats a same-cycle timeout
      if (finish) begin
        if (!m_apb_pready) begin
          resp_q <= RESP_DECERR;
        end else if (m_apb_pslverr) begin
          resp_q <= RESP_SLVERR;
        end else begin
          resp_q <= RESP_OKAY;
        end
        rdata_q <= (m_apb_pready & ~txn_q.write)
                 ? m_apb_prdata : '0;
      end
    end
  end

  assign s_axil_awready = rst_b & grant_wr;
  assign s_axil_wready  = rst_b & grant_wr;
  assign s_axil_arready = rst_b & grant_rd;
  assign s_axil_bvalid  = (state_q == ST_RESP) & txn_q.write;
  assign s_axil_rvalid  = (state_q == ST_RESP) & ~txn_q.write;
  assign s_axil_bresp   = resp_q;
  assign s_axil_rresp   = resp_q;
  assign s_axil_rdata   = rdata_q;
  assign m_apb_paddr    = txn_q.addr;
  assign m_apb_psel     = (state_q == ST_SETUP)
                        | (state_q == ST_ACCESS);
  assign m_apb_penable  = (state_q == ST_ACCESS);
  assign m_apb_pwrite   = txn_q.write;
  assign m_apb_pwdata   = txn_q.data;

endmodule

// File: tb/tb_fpga_axil_apb_bridge.sv
// Scoreboard bench for the AXI-Lite to APB bridge:
// streamed AXI stimulus, random APB completer, response monitor.
module tb_fpga_axil_apb_bridge;
  import fpga_bridge_pkg::*;

  localparam int TO = 4;

  logic        core_clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [31:0] m_apb_paddr;
  logic        m_apb_psel;
  logic        m_apb_penable;
  logic        m_apb_pwrite;
  logic [31:0] m_apb_pwdata;
  logic [31:0] m_apb_prdata = '0;
  logic        m_apb_pready = 1'b0;
  logic        m_apb_pslverr = 1'b0;

  fpga_axil_apb_bridge #(.TIMEOUT_CYC(TO)) dut (
    .core_clk      (core_clk),
    .rst_b         (rst_b),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .s_axil_araddr (s_axil_araddr),
    .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready),
    .m_apb_paddr   (m_apb_paddr),
    .m_apb_psel    (m_apb_psel),
    .m_apb_penable (m_apb_penable),
    .m_apb_pwrite  (m_apb_pwrite),
    .m_apb_pwdata  (m_apb_pwdata),
    .m_apb_prdata  (m_apb_prdata),
    .m_apb_pready  (m_apb_pready),
    .m_apb_pslverr (m_apb_pslverr)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_exp_t;

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [31:0] data;
    int          len;
  } rsp_exp_t;

  apb_exp_t    exp_apb[$];
  rsp_exp_t    exp_rsp[$];
  logic [31:0] wa_q[$], wd_q[$], ra_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, accept_cyc = 0;
  int n_exp = 0, n_got = 0;
  int pen_cnt = 0;
  int force_hang = -1, force_waits = -1, force_err = -1;
  int hold_resp = 0;
  bit fix_rd = 1'b0;
  logic [31:0] fix_rd_val = '0;
  bit chk_lat = 1'b0;
  bit wr_first = 1'b1;

  always @(negedge core_clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: got bound expiry expected completion",
             name);
  endtask

  // APB completer: picks a plan per transfer at SETUP
  initial begin : completer
    bit hang, err;
    int waits;
    logic [31:0] rd;
    apb_exp_t a;
    rsp_exp_t e;
    hang = 0; err = 0; waits = 0; rd = '0;
    a = '{wr: 1'b0, addr: '0, data: '0};
    forever begin
      @(negedge core_clk);
      if (!rst_b || !m_apb_psel) begin
        m_apb_pready = 1'b0;
        m_apb_pslverr = 1'b0;
      end else if (!m_apb_penable) begin
        m_apb_pready = 1'b0;
        m_apb_pslverr = 1'b0;
        pen_cnt = 0;
        if (exp_apb.size() == 0) begin
          fail("apb_unexpected");
        end else begin
          a = exp_apb.pop_front();
          a.addr = a.addr & 32'hFFFF_FFFC;
          chk("apb_write", m_apb_pwrite, a.wr);
          chk("apb_addr", m_apb_paddr, a.addr);
          if (a.wr) chk("apb_wdata", m_apb_pwdata, a.data);
        end
        hang = (force_hang >= 0) ? (force_hang != 0)
             : ($urandom_range(0, 9) == 0);
        err = (force_err >= 0) ? (force_err != 0)
            : ($urandom_range(0, 4) == 0);
        waits = (force_waits >= 0) ? force_waits
              : $urandom_range(0, 3);
        rd = fix_rd ? fix_rd_val : $urandom;
        e.wr = m_apb_pwrite;
        e.len = hang ? TO + 1 : waits + 1;
        e.resp = hang ? RESP_DECERR
               : (err ? RESP_SLVERR : RESP_OKAY);
        e.data = hang ? 32'h0 : rd;
        exp_rsp.push_back(e);
      end else begin
        pen_cnt++;
        chk("apb_hold_addr", m_apb_paddr, a.addr);
        if (a.wr) chk("apb_hold_wdata", m_apb_pwdata, a.data);
        if (!hang && pen_cnt == waits + 1) begin
          m_apb_pready = 1'b1;
          m_apb_pslverr = err;
          m_apb_prdata = rd;
        end else begin
          m_apb_pready = 1'b0;
          m_apb_pslverr = 1'b0;
          m_apb_prdata = $urandom;
        end
      end
    end
  end

  // response monitor: pops the scoreboard on first valid
  initial begin : monitor
    bit have, go;
    int held;
    rsp_exp_t e;
    logic [63:0] snap;
    have = 0; held = 0; go = 0; snap = '0;
    forever begin
      @(negedge core_clk);
      #1;
      if (!rst_b) begin
        s_axil_bready = 1'b0;
        s_axil_rready = 1'b0;
        have = 0;
      end else if (s_axil_bvalid || s_axil_rvalid) begin
        if (!have) begin
          have = 1;
          held = 0;
          if (exp_rsp.size() == 0) begin
            fail("resp_unexpected");
          end else begin
            e = exp_rsp.pop_front();
            chk("resp_chan", {s_axil_bvalid, s_axil_rvalid},
                e.wr ? 2'b10 : 2'b01);
            if (e.wr) begin
              chk("bresp", s_axil_bresp, e.resp);
            end else begin
              chk("rresp", s_axil_rresp, e.resp);
              chk("rdata", s_axil_rdata, e.data);
            end
            chk("access_len", pen_cnt, e.len);
          end
          chk("psel_drop", {m_apb_psel, m_apb_penable}, 0);
          if (chk_lat) begin
            chk("latency", cyc - accept_cyc, 3);
            chk_lat = 0;
          end
          snap = {s_axil_bvalid, s_axil_rvalid,
                  s_axil_bresp, s_axil_rresp,
                  s_axil_rdata, m_apb_psel};
        end else begin
          chk("resp_hold", {s_axil_bvalid, s_axil_rvalid,
                            s_axil_bresp, s_axil_rresp,
                            s_axil_rdata, m_apb_psel}, snap);
        end
        go = (held >= hold_resp)
          && (hold_resp > 0 || $urandom_range(0, 2) != 0);
        held++;
        s_axil_bready = s_axil_bvalid & go;
        s_axil_rready = s_axil_rvalid & go;
        if (go) begin
          have = 0;
          n_got++;
        end
      end else begin
        s_axil_bready = 1'b0;
        s_axil_rready = 1'b0;
      end
    end
  end

  task automatic drive_wr(input int lag);
    int n;
    @(negedge core_clk);
    while (wa_q.size() > 0) begin
      s_axil_awaddr = wa_q[0];
      s_axil_wdata = wd_q[0];
      s_axil_awvalid = 1'b1;
      s_axil_wvalid = (lag == 0);
      n = 0;
      forever begin
        #1;
        chk("aw_w_pair", s_axil_awready, s_axil_wready);
        chk("aw_gate", s_axil_awready & ~s_axil_wvalid, 0);
        if (s_axil_awready && s_axil_wvalid) break;
        if (n > 400) begin
          fail("aw_handshake");
          break;
        end
        @(negedge core_clk);
        n++;
        if (n >= lag) s_axil_wvalid = 1'b1;
      end
      accept_cyc = cyc;
      void'(wa_q.pop_front());
      void'(wd_q.pop_front());
      @(negedge core_clk);
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
  endtask

  task automatic drive_rd();
    int n;
    @(negedge core_clk);
    while (ra_q.size() > 0) begin
      s_axil_araddr = ra_q[0];
      s_axil_arvalid = 1'b1;
      n = 0;
      forever begin
        #1;
        if (s_axil_arready) break;
        if (n > 400) begin
          fail("ar_handshake");
          break;
        end
        @(negedge core_clk);
        n++;
      end
      accept_cyc = cyc;
      void'(ra_q.pop_front());
      @(negedge core_clk);
    end
    s_axil_arvalid = 1'b0;
  endtask

  // reference order: writes and reads merge, alternating
  // whenever both streams still have work
  task automatic issue(input int lag);
    int nw, nr, wi, ri, k;
    nw = wa_q.size();
    nr = ra_q.size();
    wi = 0;
    ri = 0;
    while (wi < nw || ri < nr) begin
      if (wi < nw && (ri >= nr || wr_first)) begin
        exp_apb.push_back('{wr: 1'b1, addr: wa_q[wi],
                            data: wd_q[wi]});
        if (ri < nr) wr_first = !wr_first;
        wi++;
      end else begin
        exp_apb.push_back('{wr: 1'b0, addr: ra_q[ri],
                            data: 32'h0});
        if (wi < nw) wr_first = !wr_first;
        ri++;
      end
    end
    n_exp += nw + nr;
    fork
      drive_wr((nr == 0) ? lag : 0);
      drive_rd();
    join
    k = 0;
    while (n_got != n_exp && k < 400) begin
      @(negedge core_clk);
      #2;
      k++;
    end
    if (n_got != n_exp) begin
      fail("resp_wait");
      n_got = n_exp;
    end
  endtask

  task automatic add_wr(input logic [31:0] a, d);
    wa_q.push_back(a);
    wd_q.push_back(d);
  endtask

  task automatic add_rd(input logic [31:0] a);
    ra_q.push_back(a);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit saw;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid = 1'b1;
    s_axil_arvalid = 1'b1;
    repeat (3) @(negedge core_clk);
    #1;
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_wready", s_axil_wready, 0);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_valid", {s_axil_bvalid, s_axil_rvalid}, 0);
    chk("rst_resp", {s_axil_bresp, s_axil_rresp}, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_apb_ctl", {m_apb_psel, m_apb_penable,
                        m_apb_pwrite}, 0);
    chk("rst_paddr", m_apb_paddr, 0);
    chk("rst_pwdata", m_apb_pwdata, 0);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
    s_axil_arvalid = 1'b0;
    @(negedge core_clk);
    rst_b = 1'b1;

    // contested pairs from reset: W R W R
    add_wr(32'h1000_0000, 32'h0000_0001);
    add_wr(32'h1000_0008, 32'h0000_0002);
    add_rd(32'h2000_0000);
    add_rd(32'h2000_0008);
    issue(0);

    force_waits = 0; force_err = 0; force_hang = 0;
    chk_lat = 1'b1;
    add_wr(32'h3000_0010, 32'hA5A5_0001);
    issue(0);

    force_waits = 3;
    fix_rd = 1'b1; fix_rd_val = 32'h1234_5678;
    add_rd(32'h3000_0004);
    issue(0);
    fix_rd = 1'b0;

    force_hang = 1;
    add_rd(32'h3000_0100);
    issue(0);

    force_hang = 0; force_err = 1; force_waits = 1;
    add_wr(32'h3000_0200, 32'hCAFE_F00D);
    issue(0);

    force_err = 0; force_waits = -1;
    hold_resp = 10;
    add_wr(32'h3000_0300, 32'h0BAD_BEEF);
    add_rd(32'h3000_0304);
    issue(0);
    hold_resp = 0;

    force_hang = -1; force_err = -1; force_waits = -1;
    for (int i = 0; i < 60; i++) begin
      int nw, nr;
      nw = $urandom_range(0, 3);
      nr = $urandom_range(0, 3);
      if (nw + nr == 0) nw = 1;
      for (int j = 0; j < nw; j++) add_wr($urandom, $urandom);
      for (int j = 0; j < nr; j++) add_rd($urandom);
      issue($urandom_range(0, 2));
    end

    // abort a transfer mid-ACCESS with reset
    force_hang = 1; force_err = 0;
    exp_apb.push_back('{wr: 1'b1, addr: 32'h4000_0020,
                        data: 32'hDEAD_0042});
    add_wr(32'h4000_0020, 32'hDEAD_0042);
    fork
      drive_wr(0);
    join_none
    k = 0;
    while (!m_apb_penable && k < 50) begin
      @(negedge core_clk);
      #1;
      k++;
    end
    if (!m_apb_penable) begin
      fail("reach_access");
    end else begin
      #2;
      rst_b = 1'b0;
      #1;
      chk("rst_mid_psel", {m_apb_psel, m_apb_penable}, 0);
      chk("rst_mid_valid", {s_axil_bvalid, s_axil_rvalid}, 0);
    end
    exp_rsp.delete();
    exp_apb.delete();
    wr_first = 1'b1;
    n_got = n_exp;
    repeat (2) @(negedge core_clk);
    rst_b = 1'b1;
    saw = 0;
    repeat (20) begin
      @(negedge core_clk);
      #1;
      if (s_axil_bvalid || m_apb_psel) saw = 1;
    end
    chk("rst_no_resp", saw, 0);

    force_hang = 0; force_waits = -1;
    add_wr(32'h5000_0000, 32'h0000_00AA);
    add_rd(32'h5000_0004);
    issue(0);
    add_wr(32'h5000_0010, 32'h0000_00BB);
    add_rd(32'h5000_0014);
    issue(0);

    repeat (5) @(negedge core_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpga_axil_apb_bridge.md
FPGA_AXIL_APB_BRIDGE -- requirements
Module: fpga_axil_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum ACCESS-phase wait cycles; 0 disables the timeout.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-003 core_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_b  in  1  asynchronous active-low reset.
REQ-005 s_axil_awaddr  in  32  write address.
REQ-006 s_axil_awvalid  in  1  write address valid.
REQ-007 s_axil_awready  out  1  write address accepted.
REQ-008 s_axil_wdata  in  32  write data.
REQ-009 s_axil_wvalid  in  1  write data valid.
REQ-010 s_axil_wready  out  1  write data accepted.
REQ-011 s_axil_bresp  out  2  write response.
REQ-012 s_axil_bvalid  out  1  write response valid.
REQ-013 s_axil_bready  in  1  write response taken.
REQ-014 s_axil_araddr  in  32  read address.
REQ-015 s_axil_arvalid  in  1  read address valid.
REQ-016 s_axil_arready  out  1  read address accepted.
REQ-017 s_axil_rdata  out  32  read data.
REQ-018 s_axil_rresp  out  2  read response.
REQ-019 s_axil_rvalid  out  1  read response valid.
REQ-020 s_axil_rready  in  1  read response taken.
REQ-021 m_apb_paddr  out  32  APB address; bits [1:0] always 0.
REQ-022 m_apb_psel  out  1  APB select.
REQ-023 m_apb_penable  out  1  APB enable.
REQ-024 m_apb_pwrite  out  1  APB direction; 1 = write.
REQ-025 m_apb_pwdata  out  32  APB write data.
REQ-026 m_apb_prdata  in  32  APB read data.
REQ-027 m_apb_pready  in  1  APB completer ready.
REQ-028 m_apb_pslverr  in  1  APB completer error.

Function
REQ-029 SHALL implement FSM states IDLE -> SETUP -> ACCESS -> RESP -> IDLE, with exactly one transaction outstanding at a time.
REQ-030 In IDLE, a write SHALL be accepted only when awvalid and wvalid are both high; awready and wready SHALL pulse together for that one cycle.
REQ-031 In IDLE, a read SHALL be accepted when arvalid is high, with arready pulsing for one cycle.
REQ-032 When a write and a read are both eligible in the same cycle, priority SHALL alternate: write wins first after reset, and the pointer toggles only on such contested grants.
REQ-033 Address, direction and data SHALL be registered at acceptance and held stable from SETUP through ACCESS.
REQ-034 SETUP SHALL last one cycle with psel=1 and penable=0; ACCESS SHALL drive psel=1 and penable=1 until pready=1 or a timeout.
REQ-035 The timeout counter SHALL clear on entering ACCESS, increment each ACCESS cycle, and saturate; timeout fires when count == TIMEOUT_CYC and pready=0.
REQ-036 On exiting ACCESS, psel and penable SHALL drop to 0 on the next cycle.
REQ-037 Response codes: pslverr=1 gives 2'b10 (SLVERR); timeout gives 2'b11 (DECERR); otherwise 2'b00.
REQ-038 Read data: rdata SHALL capture prdata on the pready cycle, and SHALL be 0 on timeout.
REQ-039 RESP SHALL hold bvalid/rvalid, with data and resp stable, until bready/rready; the FSM returns to IDLE on the following cycle.
REQ-040 Minimum latency SHALL be: accept at c0, SETUP at c1, ACCESS at c2 with pready=1, valid at c3.

Reset
REQ-041 While rst_b=0, all outputs SHALL be 0, the FSM SHALL be IDLE, the priority pointer SHALL point to write, and the counter SHALL be 0.
REQ-042 A reset asserted mid-transaction SHALL abort it immediately with no AXI response issued; psel SHALL deassert asynchronously.

Structure
REQ-043 Package fpga_bridge_pkg SHALL hold the FSM state enum and the response constants RESP_OKAY, RESP_SLVERR and RESP_DECERR.
REQ-044 The block SHALL be a single module with no sub-modules.

Verification
REQ-045 Write 0x3000_0010 with data 0xA5A5_0001 and pready=1 on the first ACCESS cycle -> paddr=0x3000_0010, pwdata=0xA5A5_0001, bvalid at c3, bresp=00.
REQ-046 Read 0x3000_0004 with pready after 3 wait cycles and prdata=0x1234_5678 -> rdata=0x1234_5678, rresp=00, penable high for 4 cycles.
REQ-047 Write and read asserted in the same cycle, repeated twice -> order is write, read, write, read.
REQ-048 pready held 0 with TIMEOUT_CYC=4 -> ACCESS lasts 5 cycles, rresp=11, rdata=0; pslverr=1 on a write -> bresp=10.
REQ-049 bready held 0 for 10 cycles -> bvalid and bresp stay stable and no new APB transfer starts; rst_b pulsed during ACCESS -> psel drops to 0 and bvalid never asserts.
